fill_row_sequencer: RTL and testbench
=====================================

Name: fill_row_sequencer

Overview:
- Parametrised successor to the single-pass fill controller in the 2D raster pipeline.
- Runs the edge-math step once per primitive, then sequences a row fetch and a span fill for every scanline from y_min to y_max.
- Adds row iteration, a per-phase watchdog timeout, abort, and busy/error status.
- Sits between the command decoder (fill_en) and the edge-math, row-fetch and span-fill engines.

Parameters:
COORD_W, 10, width of scanline coordinates (y_min, y_max, row_y)
TIMEOUT, 1023, max cycles a start may stay high without its done; 0 disables watchdog
TMR_W, $clog2(TIMEOUT+1) (min 1), watchdog counter width; derived, not overridden

Ports:
clk  in  1  system clock, rising edge
n_rst  in  1  asynchronous active-low reset
fill_en  in  1  start request; sampled only in IDLE
y_min  in  COORD_W  first scanline; latched on accepted fill_en
y_max  in  COORD_W  last scanline, inclusive; latched on accepted fill_en
abort  in  1  cancel current operation
math_done  in  1  edge-math engine finished
row_done  in  1  row-fetch engine finished
fill_done  in  1  span-fill engine finished
math_start  out  1  held high while in MATH
row_start  out  1  held high while in GETROW
fill_start  out  1  held high while in FILL
row_y  out  COORD_W  scanline currently being processed
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on successful completion
err  out  1  one-cycle pulse on watchdog timeout

Behaviour:
- Single clock, clk. Reset is asynchronous, active-low (n_rst); on assertion state=IDLE immediately.
- Reset values: all outputs 0; row_y=0; latched y bounds=0; watchdog=0.
- Moore outputs, registered state. At most one of math_start/row_start/fill_start is high in any cycle.
- States: IDLE, MATH, MATH_WAIT, GETROW, ROW_WAIT, FILL, FILL_WAIT, DONE, ERROR.
- IDLE:
  - fill_en=1 and y_min<=y_max: latch bounds, row_y<=y_min, go to MATH.
  - fill_en=1 and y_min>y_max (empty range): go to DONE; no start is ever asserted.
  - fill_en while busy is ignored.
- MATH: on math_done go to MATH_WAIT, else stay.
- MATH_WAIT: one cycle, all starts low, then GETROW.
- GETROW: on row_done go to ROW_WAIT, else stay.
- ROW_WAIT: one cycle, all starts low, then FILL.
- FILL: on fill_done go to FILL_WAIT, else stay.
- FILL_WAIT: one cycle, all starts low.
  - If row_y==y_max, go to DONE.
  - Else row_y<=row_y+1 and go to GETROW.
  - Increment never wraps, because y_max is at most 2^COORD_W-1 and is reached first.
- DONE: done=1 for one cycle, then IDLE.
- ERROR: err=1 for one cycle, then IDLE.
- Watchdog:
  - Cleared on every entry to MATH, GETROW or FILL; increments each cycle spent there without the matching done.
  - When the count reaches TIMEOUT, go to ERROR.
  - Saturates; inactive when TIMEOUT=0.
- Priority, highest first: n_rst > abort > matching done > watchdog expiry.
- abort in any non-IDLE state (including DONE and ERROR): next state IDLE, no done/err pulse, starts low next cycle. abort in IDLE has no effect.
- done inputs that arrive while not in the matching state are ignored.
- row_y holds its value after DONE, ERROR and abort until the next accepted fill_en.
- Latency: fill_en sampled at edge N puts math_start high in cycle N+1. Each sub-step costs its engine's response time plus one WAIT cycle.

Test Plan:
- Three-row pass:
  - Stimulus: y_min=5, y_max=7; every engine raises its done on the 3rd cycle its start is high.
  - Required: exactly 1 math_start episode; 3 row_start/fill_start episodes with row_y=5,6,7; done pulses once in cycle 29 after the fill_en edge; busy high cycles 1-29.
- Single row: y_min=y_max=12 -> one row episode with row_y=12, then done; row_y stays 12 afterwards.
- Empty range: y_min=9, y_max=4 -> done high the cycle after fill_en; math_start, row_start and fill_start never asserted.
- Timeout: TIMEOUT=8, fill_done held low -> fill_start high exactly 8 cycles, err pulses once, done never, then IDLE with busy=0.
- Abort:
  - Stimulus: abort in GETROW for row_y=6 of a 5..7 pass, with row_done asserted in the same cycle.
  - Required: IDLE next cycle, all starts 0, no done; a fresh fill_en is accepted 1 cycle later.
- Async reset: drop n_rst mid-FILL between clock edges -> all outputs 0 before the next edge; after release a new pass completes normally.

Source files
------------

// File: rtl/fill_row_sequencer_if.sv
// Handshake bundle between the command decoder / raster engines and the fill row sequencer.
`timescale 1ns/1ps
interface fill_row_sequencer_if #(
  parameter int COORD_W = 10
);
  logic               fill_en;
  logic [COORD_W-1:0] y_min;
  logic [COORD_W-1:0] y_max;
  logic               abort;
  logic               math_done;
  logic               row_done;
  logic               fill_done;
  logic               math_start;
  logic               row_start;
  logic               fill_start;
  logic [COORD_W-1:0] row_y;
  logic               busy;
  logic               done;
  logic               err;

  modport master (
    output fill_en, y_min, y_max, abort, math_done, row_done, fill_done,
    input  math_start, row_start, fill_start, row_y, busy, done, err
  );

  modport slave (
    input  fill_en, y_min, y_max, abort, math_done, row_done, fill_done,
    output math_start, row_start, fill_start, row_y, busy, done, err
  );
endinterface

// File: rtl/fill_row_sequencer.sv
// Runs edge math once per primitive, then a row fetch and span fill for each scanline
// y_min..y_max, with abort, a per-phase watchdog and registered Moore outputs.
`timescale 1ns/1ps
module fill_row_sequencer #(
  parameter int COORD_W = 10,
  parameter int TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 n_rst,
  fill_row_sequencer_if.slave  bus
);
  localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // The count is compared before incrementing, so the phase lasts exactly TIMEOUT cycles.
  localparam logic [TMR_W-1:0] TO_LAST = TMR_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  typedef enum logic [3:0] {
    IDLE, MATH, MATH_WAIT, GETROW, ROW_WAIT, FILL, FILL_WAIT, DONE, ERROR
  } state_t;

  state_t             state_q, state_d;
  logic [COORD_W-1:0] row_y_q, row_y_d;
  logic [COORD_W-1:0] ymax_q, ymax_d;
  logic [TMR_W-1:0]   wdog_q, wdog_d;
  logic               math_start_q, row_start_q, fill_start_q;
  logic               busy_q, done_q, err_q;
  logic               wdog_exp;

  assign wdog_exp = (TIMEOUT != 0) && (wdog_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    row_y_d = row_y_q;
    ymax_d  = ymax_q;
    wdog_d  = wdog_q;

    if (bus.abort && (state_q != IDLE)) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.fill_en) begin
            if (bus.y_min <= bus.y_max) begin
              ymax_d  = bus.y_max;
              row_y_d = bus.y_min;
              state_d = MATH;
            end else begin
              state_d = DONE;
            end
          end
        end
        MATH: begin
          if (bus.math_done)  state_d = MATH_WAIT;
          else if (wdog_exp)  state_d = ERROR;
        end
        MATH_WAIT: state_d = GETROW;
        GETROW: begin
          if (bus.row_done)   state_d = ROW_WAIT;
          else if (wdog_exp)  state_d = ERROR;
        end
        ROW_WAIT: state_d = FILL;
        FILL: begin
          if (bus.fill_done)  state_d = FILL_WAIT;
          else if (wdog_exp)  state_d = ERROR;
        end
        FILL_WAIT: begin
          // y_max is reached before row_y could wrap, so the increment is safe.
          if (row_y_q == ymax_q) begin
            state_d = DONE;
          end else begin
            row_y_d = row_y_q + 1'b1;
            state_d = GETROW;
          end
        end
        DONE:    state_d = IDLE;
        ERROR:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    // Any state change clears the watchdog, so each engine phase starts counting from zero.
    if (state_d != state_q) begin
      wdog_d = '0;
    end else if ((state_q == MATH) || (state_q == GETROW) || (state_q == FILL)) begin
      wdog_d = (wdog_q == {TMR_W{1'b1}}) ? wdog_q : wdog_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      row_y_q      <= '0;
      ymax_q       <= '0;
      wdog_q       <= '0;
      math_start_q <= 1'b0;
      row_start_q  <= 1'b0;
      fill_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_y_q      <= row_y_d;
      ymax_q       <= ymax_d;
      wdog_q       <= wdog_d;
      math_start_q <= (state_d == MATH);
      row_start_q  <= (state_d == GETROW);
      fill_start_q <= (state_d == FILL);
      busy_q       <= (state_d != IDLE);
      done_q       <= (state_d == DONE);
      err_q        <= (state_d == ERROR);
    end
  end

  assign bus.math_start = math_start_q;
  assign bus.row_start  = row_start_q;
  assign bus.fill_start = fill_start_q;
  assign bus.row_y      = row_y_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_fill_row_sequencer.sv
// Bench for fill_row_sequencer: responsive engine models plus a per-cycle expected timeline.
`timescale 1ns/1ps
module tb_fill_row_sequencer;
  localparam int CW = 10;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  fill_row_sequencer_if #(.COORD_W(CW)) bus();

  fill_row_sequencer #(.COORD_W(CW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [15:0]   exp_q[$];
  int            lat_arr[16];
  int            pi, cnt;
  bit            act;
  logic [CW-1:0] ry_model;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {math_start, row_start, fill_start, busy, done, err, row_y}
  function automatic logic [15:0] pk(bit ms, bit rs, bit fs, bit bz, bit dn, bit er,
                                     logic [CW-1:0] ry);
    return {ms, rs, fs, bz, dn, er, ry};
  endfunction

  function automatic logic [15:0] obs();
    return {bus.math_start, bus.row_start, bus.fill_start,
            bus.busy, bus.done, bus.err, bus.row_y};
  endfunction

  // Expected timeline: an engine phase with latency L shows its start for L cycles,
  // then one quiet cycle; latency 0 means the engine never answers.
  task automatic add_phase(input logic [2:0] st, input int lat, inout bit dead);
    if (lat == 0) begin
      repeat (TO) exp_q.push_back(pk(st[2], st[1], st[0], 1, 0, 0, ry_model));
      exp_q.push_back(pk(0, 0, 0, 1, 0, 1, ry_model));
      dead = 1;
    end else begin
      repeat (lat) exp_q.push_back(pk(st[2], st[1], st[0], 1, 0, 0, ry_model));
      exp_q.push_back(pk(0, 0, 0, 1, 0, 0, ry_model));
    end
  endtask

  task automatic build_expect(input int ymin, input int ymax);
    bit dead = 0;
    exp_q.delete();
    if (ymin > ymax) begin
      exp_q.push_back(pk(0, 0, 0, 1, 1, 0, ry_model));
      exp_q.push_back(pk(0, 0, 0, 0, 0, 0, ry_model));
      return;
    end
    ry_model = CW'(ymin);
    add_phase(3'b100, lat_arr[0], dead);
    for (int y = ymin; (y <= ymax) && !dead; y++) begin
      ry_model = CW'(y);
      add_phase(3'b010, lat_arr[1 + 2*(y - ymin)], dead);
      if (!dead) add_phase(3'b001, lat_arr[2 + 2*(y - ymin)], dead);
    end
    if (!dead) exp_q.push_back(pk(0, 0, 0, 1, 1, 0, ry_model));
    exp_q.push_back(pk(0, 0, 0, 0, 0, 0, ry_model));
  endtask

  task automatic reset_engine();
    pi = 0; cnt = 0; act = 0;
    bus.math_done = 0; bus.row_done = 0; bus.fill_done = 0;
  endtask

  // Engines answer on the L-th cycle their start is high; idle engines emit random dones.
  task automatic engine_step();
    logic [2:0] st;
    int L;
    st = {bus.math_start, bus.row_start, bus.fill_start};
    bus.math_done = ($urandom_range(0, 3) == 0);
    bus.row_done  = ($urandom_range(0, 3) == 0);
    bus.fill_done = ($urandom_range(0, 3) == 0);
    if (st != 3'b000) begin
      cnt++;
      act = 1;
      L = (pi < 16) ? lat_arr[pi] : 0;
      if (st[2]) bus.math_done = (cnt == L);
      if (st[1]) bus.row_done  = (cnt == L);
      if (st[0]) bus.fill_done = (cnt == L);
    end else if (act) begin
      act = 0;
      pi++;
      cnt = 0;
    end
  endtask

  task automatic set_lats(input int v);
    for (int j = 0; j < 16; j++) lat_arr[j] = v;
  endtask

  task automatic run_txn(input int ymin, input int ymax, input string tag);
    build_expect(ymin, ymax);
    reset_engine();
    bus.fill_en = 1;
    bus.y_min = CW'(ymin);
    bus.y_max = CW'(ymax);
    @(posedge clk); #1;
    bus.fill_en = 0;
    bus.y_min = CW'($urandom);
    bus.y_max = CW'($urandom);
    for (int i = 0; i < exp_q.size(); i++) begin
      engine_step();
      bus.fill_en = (i < exp_q.size() - 1) && ($urandom_range(0, 3) == 0);
      @(negedge clk);
      check_eq($sformatf("%s cyc%0d", tag, i + 1), 32'(obs()), 32'(exp_q[i]));
      @(posedge clk); #1;
    end
    bus.fill_en = 0;
    reset_engine();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int ymin, ymax, r;
    bit found;
    bus.fill_en = 0; bus.abort = 0; bus.y_min = '0; bus.y_max = '0;
    reset_engine();
    ry_model = '0;

    repeat (2) @(posedge clk);
    #1 check_eq("reset_state", 32'(obs()), 32'(0));
    @(negedge clk) n_rst = 1;
    @(posedge clk); #1;

    set_lats(3);
    run_txn(5, 7, "three_row");
    run_txn(12, 12, "single_row");
    repeat (2) @(posedge clk);
    #1 check_eq("row_y_hold", 32'(bus.row_y), 32'(12));
    run_txn(9, 4, "empty_range");

    set_lats(3); lat_arr[2] = 0;
    run_txn(5, 5, "timeout_fill");
    set_lats(2); lat_arr[0] = 0;
    run_txn(3, 8, "timeout_math");
    set_lats(TO);
    run_txn(1021, 1023, "done_at_limit_top");

    // Abort in GETROW for row 6 while row_done arrives in the same cycle.
    set_lats(3);
    reset_engine();
    bus.fill_en = 1; bus.y_min = CW'(5); bus.y_max = CW'(7);
    @(posedge clk); #1;
    bus.fill_en = 0;
    found = 0;
    for (int k = 0; k < 60; k++) begin
      engine_step();
      if (bus.row_start && (bus.row_y == CW'(6))) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq("abort_reach_row6", 32'(found), 32'(1));
    bus.abort = 1; bus.row_done = 1;
    @(posedge clk); #1;
    bus.abort = 0;
    reset_engine();
    @(negedge clk);
    check_eq("abort_idle", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 0, CW'(6))));
    ry_model = CW'(6);
    run_txn(20, 21, "after_abort");

    // Asynchronous reset between edges while a span fill is running.
    set_lats(3);
    reset_engine();
    bus.fill_en = 1; bus.y_min = CW'(5); bus.y_max = CW'(7);
    @(posedge clk); #1;
    bus.fill_en = 0;
    found = 0;
    for (int k = 0; k < 60; k++) begin
      engine_step();
      if (bus.fill_start) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    check_eq("rst_reach_fill", 32'(found), 32'(1));
    @(negedge clk); #2;
    n_rst = 0;
    #1 check_eq("async_rst_outputs", 32'(obs()), 32'(0));
    @(posedge clk); #1 check_eq("rst_held_outputs", 32'(obs()), 32'(0));
    reset_engine();
    @(negedge clk) n_rst = 1;
    ry_model = '0;
    @(posedge clk); #1;
    run_txn(100, 102, "post_reset");

    for (int t = 0; t < 60; t++) begin
      ymin = $urandom_range(0, 1023);
      if ((t % 8) == 7 && ymin > 0) ymax = $urandom_range(0, ymin - 1);
      else if ((t % 10) == 5) begin ymin = 1020; ymax = 1023; end
      else ymax = (ymin + 3 > 1023) ? 1023 : ymin + $urandom_range(0, 3);
      for (int j = 0; j < 16; j++) begin
        r = $urandom_range(0, 29);
        lat_arr[j] = (r == 0) ? 0 : (r < 4) ? TO : $urandom_range(1, 4);
      end
      run_txn(ymin, ymax, $sformatf("rand%0d", t));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        check_eq("idle_gap", 32'(obs()), 32'(pk(0, 0, 0, 0, 0, 0, ry_model)));
        @(posedge clk); #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
